// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: polls the RS232 core over Avalon-MM, parses framed host
// packets (sync, len, payload, xor checksum), streams payload bytes to the
// matrix loader and writes an ACK/NAK reply back through the same core.
module uart_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15,
  parameter int         TIMEOUT_CYC = 50_000_000,
  parameter int         TW          = 26
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  output logic        uart_address,
  output logic        uart_chipselect,
  output logic [3:0]  uart_byteenable,
  output logic        uart_read,
  output logic        uart_write,
  output logic [31:0] uart_writedata,
  input  logic [31:0] uart_readdata,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [2:0] S_RD   = 3'd0;
  localparam logic [2:0] S_CAP  = 3'd1;
  localparam logic [2:0] S_OUT  = 3'd2;
  localparam logic [2:0] S_WSP  = 3'd3;
  localparam logic [2:0] S_WCAP = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;

  localparam logic [1:0] P_SYNC = 2'd0;
  localparam logic [1:0] P_LEN  = 2'd1;
  localparam logic [1:0] P_PAY  = 2'd2;
  localparam logic [1:0] P_CHK  = 2'd3;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]    state;
  logic [1:0]    phase;
  logic [7:0]    cnt, chk, data_q, reply_q;
  logic          last_q;
  logic [TW-1:0] timer;

  logic [7:0] rx_byte;
  logic       rvalid, wspace, cap_vld, polling, tmo;
  logic       done_c, err_c;
  logic       unused_bits;

  assign rx_byte     = uart_readdata[7:0];
  assign rvalid      = uart_readdata[15];
  assign wspace      = (uart_readdata[31:16] != 16'h0);
  assign unused_bits = ^uart_readdata[14:8];

  // A byte is only "received" when the data-register capture shows RVALID.
  assign cap_vld = (state == S_CAP) && rvalid;
  // The idle timer only runs while actively polling inside a frame.
  assign polling = (phase != P_SYNC) && ((state == S_RD) || (state == S_CAP));
  // A byte arriving in the same cycle wins over the timeout.
  assign tmo     = polling && (timer == TMO_LAST) && !cap_vld;

  // Frame-end pulses are decoded in the cycle that evaluates the byte.
  always_comb begin
    done_c = 1'b0;
    err_c  = 1'b0;
    if (tmo) begin
      err_c = 1'b1;
    end else if (cap_vld) begin
      case (phase)
        P_LEN:   err_c  = (rx_byte == 8'h00);
        P_CHK: begin
          done_c = (rx_byte == chk);
          err_c  = (rx_byte != chk);
        end
        default: ;
      endcase
    end
  end

  // Bus strobes are state decodes, held off while reset is asserted.
  // The data read in S_RD is suppressed when the timeout fires so no
  // byte is popped and then dropped.
  assign uart_read       = !reset_reset && (((state == S_RD) && !tmo) || (state == S_WSP));
  assign uart_write      = !reset_reset && (state == S_WR);
  assign uart_address    = uart_read && (state == S_WSP);
  assign uart_chipselect = uart_read || uart_write;
  assign uart_byteenable = {4{uart_chipselect}};
  assign uart_writedata  = uart_write ? {24'h0, reply_q} : 32'h0;

  assign m_valid    = (state == S_OUT);
  assign m_data     = data_q;
  assign m_last     = last_q && m_valid;
  assign frame_done = done_c && !reset_reset;
  assign frame_err  = err_c && !reset_reset;
  assign busy       = (phase != P_SYNC);

  // Idle timer: restarts on every received byte and whenever back in SYNC.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      timer <= '0;
    else if (cap_vld || tmo || (phase == P_SYNC))
      timer <= '0;
    else if (polling)
      timer <= timer + TW'(1);
  end

  // Bus sequencer and frame parser.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state   <= S_RD;
      phase   <= P_SYNC;
      cnt     <= 8'h0;
      chk     <= 8'h0;
      data_q  <= 8'h0;
      last_q  <= 1'b0;
      reply_q <= 8'h0;
    end else begin
      case (state)
        S_RD: begin
          if (tmo) begin
            phase   <= P_SYNC;
            reply_q <= NAK_BYTE;
            state   <= S_WSP;
          end else begin
            state <= S_CAP;
          end
        end
        S_CAP: begin
          if (tmo) begin
            phase   <= P_SYNC;
            reply_q <= NAK_BYTE;
            state   <= S_WSP;
          end else if (!rvalid) begin
            state <= S_RD;
          end else begin
            case (phase)
              P_SYNC: begin
                if (rx_byte == SYNC_BYTE) phase <= P_LEN;
                state <= S_RD;
              end
              P_LEN: begin
                if (rx_byte == 8'h00) begin
                  phase   <= P_SYNC;
                  reply_q <= NAK_BYTE;
                  state   <= S_WSP;
                end else begin
                  cnt   <= rx_byte;
                  chk   <= rx_byte;
                  phase <= P_PAY;
                  state <= S_RD;
                end
              end
              P_PAY: begin
                data_q <= rx_byte;
                last_q <= (cnt == 8'd1);
                chk    <= chk ^ rx_byte;
                cnt    <= cnt - 8'd1;
                state  <= S_OUT;
              end
              default: begin
                reply_q <= (rx_byte == chk) ? ACK_BYTE : NAK_BYTE;
                phase   <= P_SYNC;
                state   <= S_WSP;
              end
            endcase
          end
        end
        S_OUT: begin
          if (m_ready) begin
            if (cnt == 8'h0) phase <= P_CHK;
            state <= S_RD;
          end
        end
        S_WSP:   state <= S_WCAP;
        S_WCAP:  state <= wspace ? S_WR : S_WSP;
        S_WR:    state <= S_RD;
        default: state <= S_RD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: UART core model with an rx byte queue, frame-level
// reference model, directed scenarios then randomized frames.
module tb_uart_rx_ctrl;
  typedef logic [7:0] pl_t [8];

  logic        clk = 1'b0;
  logic        reset_reset;
  logic        uart_address, uart_chipselect, uart_read, uart_write;
  logic [3:0]  uart_byteenable;
  logic [31:0] uart_writedata;
  logic [31:0] uart_readdata = 32'h0;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_ready;
  logic        frame_done, frame_err, busy;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.TIMEOUT_CYC(64), .TW(8)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .uart_address(uart_address), .uart_chipselect(uart_chipselect),
    .uart_byteenable(uart_byteenable), .uart_read(uart_read),
    .uart_write(uart_write), .uart_writedata(uart_writedata),
    .uart_readdata(uart_readdata),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  int compared = 0, mismatched = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART core model: 1-cycle read latency, rx FIFO pops on data reads.
  logic [7:0]  rxq[$];
  logic [15:0] wspace_val = 16'h0010;
  int          cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_read && !uart_address) begin
      if (rxq.size() != 0) uart_readdata <= {16'h0, 1'b1, 7'h0, rxq.pop_front()};
      else                 uart_readdata <= 32'h0;
    end else if (uart_read) begin
      uart_readdata <= {wspace_val, 16'h0};
    end else begin
      uart_readdata <= 32'h0;
    end
  end

  // Loader ready: 0 = held low, 1 = held high, 2 = random.
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    m_ready = (rdy_mode == 2) ? 1'($urandom) : (rdy_mode == 1);
  end

  // Monitor: records handshakes, writes, pulses; checks cycle invariants.
  logic [8:0]  obs_pay[$];
  logic [32:0] obs_wr[$];
  int n_done = 0, n_err = 0, n_wsp = 0, err_cyc = 0, acc_cyc = 0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [8:0] pd = 9'h0;
  always @(negedge clk) begin
    if (uart_write) obs_wr.push_back({uart_address, uart_writedata});
    if (frame_done) n_done++;
    if (frame_err) begin n_err++; err_cyc = cyc; end
    if (!reset_reset) begin
      if (m_valid && pv && !pr) check("m_hold", {m_last, m_data}, pd);
      if (m_valid) check("no_pop_in_out", uart_read && !uart_address, 1'b0);
      if (frame_done || frame_err) check("pulse_excl", frame_done && frame_err, 1'b0);
      if (uart_write) check("wr_be", uart_byteenable, 4'hF);
      if (m_valid && m_ready) begin obs_pay.push_back({m_last, m_data}); acc_cyc = cyc; end
      if (uart_read && uart_address) n_wsp++;
      pv = m_valid; pr = m_ready; pd = {m_last, m_data};
    end else begin
      pv = 1'b0;
    end
  end

  // Reference model: frame-level expectations.
  logic [8:0] exp_pay[$];
  logic [7:0] exp_wr[$];
  int exp_done = 0, exp_err = 0;

  task automatic send_frame(logic [7:0] len, pl_t pl, logic [7:0] ck);
    logic [7:0] x;
    rxq.push_back(8'hA5);
    rxq.push_back(len);
    if (len == 8'h0) begin
      exp_wr.push_back(8'h15);
      exp_err++;
    end else begin
      x = len;
      for (int i = 0; i < int'(len); i++) begin
        rxq.push_back(pl[i]);
        exp_pay.push_back({(i == int'(len) - 1), pl[i]});
        x ^= pl[i];
      end
      rxq.push_back(ck);
      if (ck == x) begin exp_wr.push_back(8'h06); exp_done++; end
      else         begin exp_wr.push_back(8'h15); exp_err++;  end
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(int budget);
    int b = 0;
    while (obs_wr.size() < exp_wr.size() && b < budget) begin step(1); b++; end
    step(6);
  endtask

  task automatic wait_valid(string tag);
    int b = 0;
    while (!m_valid && b < 60) begin step(1); b++; end
    check(tag, m_valid, 1'b1);
  endtask

  task automatic drain(string tag);
    check({tag, "_npay"}, obs_pay.size(), exp_pay.size());
    while (obs_pay.size() != 0 && exp_pay.size() != 0)
      check({tag, "_pay"}, obs_pay.pop_front(), exp_pay.pop_front());
    check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    while (obs_wr.size() != 0 && exp_wr.size() != 0)
      check({tag, "_wr"}, obs_wr.pop_front(), {1'b0, 24'h0, exp_wr.pop_front()});
    check({tag, "_done"}, n_done, exp_done);
    check({tag, "_err"}, n_err, exp_err);
    obs_pay.delete(); exp_pay.delete(); obs_wr.delete(); exp_wr.delete();
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_ctl"}, {uart_read, uart_write, uart_chipselect, uart_byteenable,
                          uart_address, m_valid, m_last, frame_done, frame_err, busy}, 0);
    check({tag, "_wd"}, uart_writedata, 32'h0);
    check({tag, "_md"}, m_data, 8'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    pl_t p;
    logic [7:0] x, nb;
    int w0, b, ln;
    bit good;

    reset_reset = 1'b1;
    step(3);
    check_reset_outs("rst");
    reset_reset = 1'b0;
    #1;
    check("first_rd", {uart_read, uart_address, uart_chipselect, uart_byteenable}, {3'b101, 4'hF});
    step(1);
    check("poll_gap", uart_read, 1'b0);
    step(1);
    check("poll_again", uart_read, 1'b1);

    // Good 3-byte frame, then the same with a bad checksum.
    p = '{8'h11, 8'h22, 8'h33, 0, 0, 0, 0, 0};
    send_frame(8'd3, p, 8'h03);
    wait_wr(300); drain("good3");
    send_frame(8'd3, p, 8'h04);
    wait_wr(300); drain("bad3");

    // Noise ahead of a one-byte frame.
    rxq.push_back(8'h00); rxq.push_back(8'hFF); rxq.push_back(8'hA4);
    p = '{8'h7E, 0, 0, 0, 0, 0, 0, 0};
    send_frame(8'd1, p, 8'h7F);
    wait_wr(300); drain("noise");

    // Zero length, then a valid frame right behind it.
    send_frame(8'd0, p, 8'h00);
    p = '{8'h5A, 8'hA5, 0, 0, 0, 0, 0, 0};
    send_frame(8'd2, p, 8'hFD);
    wait_wr(400); drain("len0");

    // Loader stalls for 100 cycles mid-payload.
    rdy_mode = 0;
    p = '{8'h11, 8'h22, 0, 0, 0, 0, 0, 0};
    send_frame(8'd2, p, 8'h31);
    wait_valid("stall_valid");
    step(100);
    check("stall_still_valid", m_valid, 1'b1);
    check("stall_noerr", n_err, exp_err);
    rdy_mode = 1;
    wait_wr(300); drain("stall");

    // Stream stops after A5 02 11: timeout NAK 64 polling cycles later.
    rxq.push_back(8'hA5); rxq.push_back(8'h02); rxq.push_back(8'h11);
    exp_pay.push_back({1'b0, 8'h11});
    exp_wr.push_back(8'h15);
    exp_err++;
    wait_wr(400);
    check("tmo_latency", err_cyc - acc_cyc, 64);
    drain("tmo");

    // No reply write while WSPACE reads back zero.
    wspace_val = 16'h0;
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0};
    send_frame(8'd4, p, 8'h04 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
    w0 = n_wsp; b = 0;
    while (n_wsp < w0 + 10 && b < 600) begin step(1); b++; end
    check("wsp_polls", n_wsp >= w0 + 10, 1'b1);
    check("wsp_nowr", obs_wr.size(), 0);
    wspace_val = 16'h0003;
    wait_wr(300); drain("wsp");

    // Reset in the middle of the payload.
    rdy_mode = 0;
    rxq.push_back(8'hA5); rxq.push_back(8'h03); rxq.push_back(8'h11);
    rxq.push_back(8'h22); rxq.push_back(8'h33); rxq.push_back(8'h03);
    wait_valid("mid_valid");
    reset_reset = 1'b1;
    step(1);
    check_reset_outs("midrst");
    reset_reset = 1'b0;
    rxq.delete();
    rdy_mode = 1;
    step(30);
    check("midrst_nowr", obs_wr.size(), 0);
    check("midrst_idle", busy, 1'b0);
    obs_pay.delete();
    p = '{8'hC3, 8'h3C, 0, 0, 0, 0, 0, 0};
    send_frame(8'd2, p, 8'h02 ^ 8'hC3 ^ 8'h3C);
    wait_wr(300); drain("after_rst");

    // Randomized frames with noise and random loader backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        do nb = 8'($urandom); while (nb == 8'hA5);
        rxq.push_back(nb);
      end
      ln = $urandom_range(0, 8);
      x = 8'(ln);
      for (int i = 0; i < 8; i++) begin
        p[i] = 8'($urandom);
        if (i < ln) x ^= p[i];
      end
      good = 1'($urandom);
      send_frame(8'(ln), p, good ? x : x ^ 8'($urandom_range(1, 255)));
    end
    wait_wr(6000); drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
